morse_letter_decoder: RTL and testbench

Parametrised Morse key decoder: times a debounced active-low key input in units of `TIMER_FINAL_VALUE+1` clocks, classifies dots and dashes, and assembles letters. Each completed letter is pushed as an ASCII byte into an internal FIFO that the display/host side pops with `read`. It supersedes the fixed single-width decoder: timing thresholds, maximum letter length and FIFO depth are parameters, and it adds unknown-pattern detection, full/drop reporting and word-space insertion.

---
 rtl/morse_pkg.sv | 80 ++++++++
 rtl/morse_fifo.sv | 69 ++++++
 rtl/morse_letter_decoder.sv | 148 ++++++++++++++
 tb/tb_morse_letter_decoder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types, ASCII constants and the ITU Morse pattern table for the letter decoder.
// Patterns are stored first-element-in-bit-0 with dash=1.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_WORD_WAIT
  } morse_state_e;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

  // Bit strings below read as the Morse code reversed (last element on the left).
  function automatic logic [7:0] morse_lookup(input logic [2:0] count, input logic [6:0] pattern);
    logic [7:0] ch;
    ch = ASCII_UNKNOWN;
    if (pattern[6:5] == 2'b00) begin
      case (count)
        3'd1: ch = pattern[0] ? "T" : "E";
        3'd2: begin
          case (pattern[1:0])
            2'b00:   ch = "I";
            2'b10:   ch = "A";
            2'b01:   ch = "N";
            default: ch = "M";
          endcase
        end
        3'd3: begin
          case (pattern[2:0])
            3'b000:  ch = "S";
            3'b100:  ch = "U";
            3'b010:  ch = "R";
            3'b110:  ch = "W";
            3'b001:  ch = "D";
            3'b101:  ch = "K";
            3'b011:  ch = "G";
            default: ch = "O";
          endcase
        end
        3'd4: begin
          case (pattern[3:0])
            4'b0000: ch = "H";
            4'b1000: ch = "V";
            4'b0100: ch = "F";
            4'b0010: ch = "L";
            4'b0110: ch = "P";
            4'b1110: ch = "J";
            4'b0001: ch = "B";
            4'b1001: ch = "X";
            4'b0101: ch = "C";
            4'b1101: ch = "Y";
            4'b0011: ch = "Z";
            4'b1011: ch = "Q";
            default: ch = ASCII_UNKNOWN;
          endcase
        end
        3'd5: begin
          case (pattern[4:0])
            5'b11110: ch = "1";
            5'b11100: ch = "2";
            5'b11000: ch = "3";
            5'b10000: ch = "4";
            5'b00000: ch = "5";
            5'b00001: ch = "6";
            5'b00011: ch = "7";
            5'b00111: ch = "8";
            5'b01111: ch = "9";
            5'b11111: ch = "0";
            default:  ch = ASCII_UNKNOWN;
          endcase
        end
        default: ch = ASCII_UNKNOWN;
      endcase
    end
    return ch;
  endfunction

endpackage

// File: rtl/morse_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head, full/empty flags
// and a drop strobe for pushes refused while full.
module morse_fifo #(
  parameter int ADDR_W = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] wr_data,
  input  logic       read,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
  logic            empty_reg, full_reg;
  logic [7:0]      rd_data_reg, head_next;
  logic            do_push, do_pop;

  // A read frees a slot in the same cycle, so a push while full still lands.
  assign do_push = push && (!full_reg || read);
  assign do_pop  = read && !empty_reg;
  assign drop    = push && full_reg && !read;

  assign wr_ptr_next = wr_ptr_reg + {{ADDR_W{1'b0}}, do_push};
  assign rd_ptr_next = rd_ptr_reg + {{ADDR_W{1'b0}}, do_pop};

  always_comb begin
    head_next = mem[rd_ptr_next[ADDR_W-1:0]];
    if (wr_ptr_next == rd_ptr_next) begin
      head_next = 8'h00;
    end else if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
      head_next = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      empty_reg   <= 1'b1;
      full_reg    <= 1'b0;
      rd_data_reg <= 8'h00;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      empty_reg   <= (wr_ptr_next == rd_ptr_next);
      full_reg    <= (wr_ptr_next[ADDR_W] != rd_ptr_next[ADDR_W]) &&
                     (wr_ptr_next[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]);
      rd_data_reg <= head_next;
    end
  end

  assign rd_data = rd_data_reg;
  assign empty   = empty_reg;
  assign full    = full_reg;

endmodule

// File: rtl/morse_letter_decoder.sv
// Morse key decoder: times key marks/spaces in units, assembles letters and queues ASCII.
// Define MORSE_WORD_SPACE_EN to also queue 0x20 after each word gap.
module morse_letter_decoder
  import morse_pkg::*;
#(
  parameter int TIMER_FINAL_VALUE = 5,
  parameter int DASH_UNITS        = 2,
  parameter int LETTER_GAP_UNITS  = 3,
  parameter int WORD_GAP_UNITS    = 7,
  parameter int MAX_ELEMS         = 6,
  parameter int FIFO_ADDR_W       = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       b,
  input  logic       read,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       drop
);

  localparam int TICK_W = (TIMER_FINAL_VALUE > 0) ? $clog2(TIMER_FINAL_VALUE + 1) : 1;
  localparam int UNIT_W = $clog2(WORD_GAP_UNITS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TIMER_FINAL_VALUE);
  localparam logic [UNIT_W-1:0] DASH_U    = UNIT_W'(DASH_UNITS);
  localparam logic [UNIT_W-1:0] LETTER_U  = UNIT_W'(LETTER_GAP_UNITS);
  localparam logic [UNIT_W-1:0] WORD_U    = UNIT_W'(WORD_GAP_UNITS);
  localparam logic [2:0]        MAX_COUNT = 3'(MAX_ELEMS);

  morse_state_e         state_reg, state_next;
  logic [TICK_W-1:0]    tick_reg;
  logic [UNIT_W-1:0]    units_reg, units_inc;
  logic [MAX_ELEMS-1:0] pattern_reg, pattern_next;
  logic [2:0]           count_reg, count_next;
  logic                 ovf_reg, ovf_next;
  logic                 wrap, clear_cnt, push;
  logic [7:0]           push_data, letter;
  logic [6:0]           pattern_ext;

  assign wrap      = (tick_reg == TICK_LAST);
  assign units_inc = (wrap && (units_reg != WORD_U)) ? units_reg + 1'b1 : units_reg;

  // The gap keeps being timed across SPACE->WORD_WAIT so the word gap counts from key release.
  assign clear_cnt = (state_next != state_reg) &&
                     !((state_reg == ST_SPACE) && (state_next == ST_WORD_WAIT));

  always_comb begin
    pattern_ext = '0;
    pattern_ext[MAX_ELEMS-1:0] = pattern_reg;
  end

  assign letter = ovf_reg ? ASCII_UNKNOWN : morse_lookup(count_reg, pattern_ext);

  always_comb begin
    state_next   = state_reg;
    pattern_next = pattern_reg;
    count_next   = count_reg;
    ovf_next     = ovf_reg;
    push         = 1'b0;
    push_data    = letter;
    case (state_reg)
      ST_IDLE: begin
        if (!b) begin
          state_next   = ST_MARK;
          pattern_next = '0;
          count_next   = '0;
          ovf_next     = 1'b0;
        end
      end
      ST_MARK: begin
        if (b) begin
          state_next = ST_SPACE;
          // Include the unit completing on this edge so a mark of exactly N units counts as N.
          if (count_reg == MAX_COUNT) begin
            ovf_next = 1'b1;
          end else begin
            pattern_next[count_reg] = (units_inc >= DASH_U);
            count_next              = count_reg + 3'd1;
          end
        end
      end
      ST_SPACE: begin
        if (!b) begin
          state_next = ST_MARK;
        end else if (units_reg >= LETTER_U) begin
          state_next = ST_WORD_WAIT;
          push       = 1'b1;
        end
      end
      ST_WORD_WAIT: begin
        if (!b) begin
          state_next   = ST_MARK;
          pattern_next = '0;
          count_next   = '0;
          ovf_next     = 1'b0;
        end else if (units_reg >= WORD_U) begin
          state_next = ST_IDLE;
`ifdef MORSE_WORD_SPACE_EN
          push       = 1'b1;
          push_data  = ASCII_SPACE;
`else
          push       = 1'b0;
`endif
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      tick_reg    <= '0;
      units_reg   <= '0;
      pattern_reg <= '0;
      count_reg   <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pattern_reg <= pattern_next;
      count_reg   <= count_next;
      ovf_reg     <= ovf_next;
      if (clear_cnt) begin
        tick_reg  <= '0;
        units_reg <= '0;
      end else begin
        tick_reg  <= wrap ? '0 : tick_reg + 1'b1;
        units_reg <= units_inc;
      end
    end
  end

  morse_fifo #(
    .ADDR_W(FIFO_ADDR_W)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .wr_data(push_data),
    .read   (read),
    .rd_data(rd_data),
    .empty  (empty),
    .full   (full),
    .drop   (drop)
  );

endmodule

// File: tb/tb_morse_letter_decoder.sv
// Scoreboard bench for morse_letter_decoder at default parameters (unit = 6 clocks).
module tb_morse_letter_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       b = 1'b1;
  logic       read = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, drop;

  int n_cmp = 0;
  int n_bad = 0;
  int drop_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  morse_letter_decoder dut (
    .clk    (clk),
    .reset_n(reset_n),
    .b      (b),
    .read   (read),
    .rd_data(rd_data),
    .empty  (empty),
    .full   (full),
    .drop   (drop)
  );

  always @(negedge clk) begin
    if (drop === 1'b1) drop_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic key(input logic level, input int n);
    b = level;
    repeat (n) @(negedge clk);
  endtask

  // Leaves b released at the negedge right after the last mark.
  task automatic send_marks(input string code);
    for (int i = 0; i < code.len(); i++) begin
      if (i != 0) key(1'b1, 6);
      key(1'b0, (code.getc(i) == 8'h2D) ? 12 : 6);
    end
    b = 1'b1;
  endtask

  task automatic expect_push(input logic [7:0] ch);
    if (exp_q.size() < 8) exp_q.push_back(ch);
  endtask

  task automatic expect_word_space();
`ifdef MORSE_WORD_SPACE_EN
    expect_push(8'h20);
`endif
  endtask

  task automatic letter(input string code, input logic [7:0] ch);
    send_marks(code);
    expect_push(ch);
    key(1'b1, 50);
    expect_word_space();
  endtask

  task automatic drain(input string tag);
    logic [7:0] want;
    int waited;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      waited = 0;
      while (empty && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      check({tag, " not_empty"}, {31'd0, empty}, 32'd0);
      check({tag, " data"}, {24'd0, rd_data}, {24'd0, want});
      $display("[%0t] %s pop 0x%02h expected 0x%02h", $time, tag, rd_data, want);
      read = 1'b1;
      @(negedge clk);
      read = 1'b0;
    end
    check({tag, " empty_after"}, {31'd0, empty}, 32'd1);
  endtask

  initial begin
    int lat;
    int d0;
    repeat (3) @(negedge clk);
    check("reset empty", {31'd0, empty}, 32'd1);
    check("reset full", {31'd0, full}, 32'd0);
    check("reset drop", {31'd0, drop}, 32'd0);
    check("reset rd_data", {24'd0, rd_data}, 32'h00);
    reset_n = 1'b1;
    @(negedge clk);

    // Single dot with push latency measured from the release edge.
    send_marks(".");
    expect_push("E");
    lat = 0;
    @(posedge clk);
    while (lat < 200) begin
      @(negedge clk);
      if (!empty) break;
      @(posedge clk);
      lat++;
    end
    check("E latency", lat, 19);
    key(1'b1, 40);
    expect_word_space();
    drain("E");
    check("no drop", drop_cnt, 0);

    letter(".-", "A");
    drain("A");
    letter("-.-.", "C");
    letter("-----", "0");
    letter(".----", "1");
    drain("mix");
    letter(".......", 8'h3F);
    drain("ovf");
    letter("......", 8'h3F);
    drain("unknown");

    // Fill the FIFO with nine letters and no reads.
    d0 = drop_cnt;
    for (int i = 1; i <= 9; i++) begin
      send_marks(".");
      expect_push("E");
      key(1'b1, 25);
      if (i == 7) check("full after 7", {31'd0, full}, 32'd0);
      if (i == 8) check("full after 8", {31'd0, full}, 32'd1);
    end
    check("drop pulses on 9th", drop_cnt - d0, 1);
    check("full after 9", {31'd0, full}, 32'd1);

    // Read lined up with the push edge while full.
    check("head before swap", {24'd0, rd_data}, {24'd0, exp_q[0]});
    d0 = drop_cnt;
    send_marks(".");
    repeat (19) @(negedge clk);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    void'(exp_q.pop_front());
    expect_push("E");
    check("full after swap", {31'd0, full}, 32'd1);
    check("no drop on swap", drop_cnt - d0, 0);
    key(1'b1, 40);
    expect_word_space();
    drain("full");

    // Reset in the middle of a dash with one letter already queued.
    send_marks(".");
    expect_push("E");
    key(1'b1, 25);
    check("queued before reset", {31'd0, empty}, 32'd0);
    key(1'b0, 9);
    reset_n = 1'b0;
    b = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    check("mid-dash reset empty", {31'd0, empty}, 32'd1);
    check("mid-dash reset rd_data", {24'd0, rd_data}, 32'h00);
    key(1'b1, 60);
    check("no push after reset", {31'd0, empty}, 32'd1);
    check("rd_data after reset", {24'd0, rd_data}, 32'h00);
    check("full after reset", {31'd0, full}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
